// File: rtl/soc_system_led_ctrl.sv
`default_nettype none
// ============================================================================
// soc_system_led_ctrl : Avalon-MM LED controller with set/clear/toggle, blink
// and optional PWM brightness (define SOC_LED_PWM_EN). Rev 1.0
// ============================================================================
module soc_system_led_ctrl #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam int PRE_W = $clog2(CLK_DIV);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE = 3'd3;
  localparam logic [2:0] ADDR_MASK   = 3'd4;
  localparam logic [2:0] ADDR_HALF   = 3'd5;
  localparam logic [2:0] ADDR_DUTY   = 3'd6;
  localparam logic [2:0] ADDR_STATUS = 3'd7;

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic             unused_wd;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [15:0]      half_q, half_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [15:0]      bcnt_q, bcnt_d;
  logic             phase_q, phase_d;
  logic             tick;
  logic             pwm_on;
  logic [WIDTH-1:0] eff;

  assign wr_en     = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  assign tick  = (pre_q == PRE_W'(CLK_DIV - 1));
  assign pre_d = tick ? '0 : pre_q + PRE_W'(1);

  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    half_d = half_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:   data_d = wd;
        ADDR_SET:    data_d = data_q | wd;
        ADDR_CLEAR:  data_d = data_q & ~wd;
        ADDR_TOGGLE: data_d = data_q ^ wd;
        ADDR_MASK:   mask_d = wd;
        ADDR_HALF:   half_d = writedata[15:0];
        default:     ;
      endcase
    end
  end

  // A BLINK_HALF write restarts the blink timebase and wins over a coincident tick.
  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (wr_en && (address == ADDR_HALF)) begin
      bcnt_d  = 16'd0;
      phase_d = 1'b0;
    end else if (tick && (half_q != 16'd0)) begin
      if (bcnt_q == half_q - 16'd1) begin
        bcnt_d  = 16'd0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d  = bcnt_q + 16'd1;
      end
    end
  end

`ifdef SOC_LED_PWM_EN
  logic [7:0] duty_q, duty_d;
  logic [7:0] pwm_cnt_q;

  assign duty_d = (wr_en && (address == ADDR_DUTY)) ? writedata[7:0] : duty_q;
  assign pwm_on = (duty_q == 8'hFF) | (pwm_cnt_q < duty_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_q    <= 8'hFF;
      pwm_cnt_q <= 8'd0;
    end else begin
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
    end
  end
`else
  assign pwm_on = 1'b1;
`endif

  assign eff = data_q & (~mask_q | {WIDTH{phase_q}}) & {WIDTH{pwm_on}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= '0;
      mask_q   <= '0;
      half_q   <= 16'd0;
      pre_q    <= '0;
      bcnt_q   <= 16'd0;
      phase_q  <= 1'b0;
      out_port <= '0;
    end else begin
      data_q   <= data_d;
      mask_q   <= mask_d;
      half_q   <= half_d;
      pre_q    <= pre_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      out_port <= eff;
    end
  end

  always_comb begin
    readdata = 32'h0;
    case (address)
      ADDR_DATA:   readdata = 32'(data_q);
      ADDR_MASK:   readdata = 32'(mask_q);
      ADDR_HALF:   readdata = {16'h0, half_q};
`ifdef SOC_LED_PWM_EN
      ADDR_DUTY:   readdata = {24'h0, duty_q};
`else
      ADDR_DUTY:   readdata = 32'h0;
`endif
      ADDR_STATUS: readdata = {30'h0, tick, phase_q};
      default:     readdata = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_soc_system_led_ctrl.sv
`default_nettype none
// ============================================================================
// tb_soc_system_led_ctrl : directed vector bench for soc_system_led_ctrl
// (WIDTH=8, CLK_DIV=4); PWM checks follow SOC_LED_PWM_EN. Rev 1.0
// ============================================================================
module tb_soc_system_led_ctrl;

  localparam int WIDTH   = 8;
  localparam int CLK_DIV = 4;
  localparam int HP      = 3 * CLK_DIV;  // clk cycles per phase with BLINK_HALF=3

`ifdef SOC_LED_PWM_EN
  localparam bit          PWM      = 1'b1;
  localparam logic [31:0] DUTY_RST = 32'h0000_00FF;
`else
  localparam bit          PWM      = 1'b0;
  localparam logic [31:0] DUTY_RST = 32'h0000_0000;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;

  int n_chk  = 0;
  int n_fail = 0;
  int m_pre;

  always #5 clk = ~clk;

  soc_system_led_ctrl #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  // Free-running prescaler reference, used to place writes relative to ticks.
  always @(posedge clk or posedge reset) begin
    if (reset) m_pre <= 0;
    else       m_pre <= (m_pre == CLK_DIV - 1) ? 0 : m_pre + 1;
  end

  typedef struct {
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [31:0] exp_data;
    logic [7:0]  exp_out;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Call just after a negedge; returns 1ns after the write edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input string name, input logic [31:0] exp);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  task automatic align(input int p);
    @(negedge clk);
    for (int i = 0; i < CLK_DIV && m_pre != p; i++) @(negedge clk);
    check("align", m_pre, p);
  endtask

  function automatic logic phase_at(input int j, input int t);
    if (j < t) return 1'b0;
    return (((j - t) / HP + 1) % 2) == 1;
  endfunction

  // Samples after edges N+1..N+3*HP following a BLINK_HALF=3 write at edge N.
  task automatic blink_run(input int t);
    for (int k = 1; k <= 3 * HP; k++) begin
      @(posedge clk);
      #1;
      check("blink_out", {24'h0, out_port}, {24'h0, 7'h7F, phase_at(k - 1, t)});
      address = 3'd7;
      #1;
      check("blink_phase", {31'h0, readdata[0]}, {31'h0, phase_at(k, t)});
    end
  endtask

  task automatic pwm_run(input logic [7:0] duty, input int exp_cnt);
    int cnt;
    @(negedge clk);
    wr(3'd6, {24'h0, duty});
    rd(3'd6, "duty_read", PWM ? {24'h0, duty} : 32'h0);
    cnt = 0;
    for (int k = 0; k < 256; k++) begin
      @(posedge clk);
      #1;
      if (out_port[0]) cnt++;
    end
    check("pwm_on_count", cnt, exp_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_chk %0d", n_chk);
    $fatal(1);
  end

  initial begin
    logic [7:0] prev_out;
    int         found;

    tbl[0]  = '{3'd0, 32'h0000_00A5, 32'h0000_00A5, 32'h0000_00A5, 8'hA5};
    tbl[1]  = '{3'd0, 32'h0000_00F0, 32'h0000_00F0, 32'h0000_00F0, 8'hF0};
    tbl[2]  = '{3'd1, 32'h0000_000F, 32'h0,         32'h0000_00FF, 8'hFF};
    tbl[3]  = '{3'd2, 32'h0000_0030, 32'h0,         32'h0000_00CF, 8'hCF};
    tbl[4]  = '{3'd3, 32'h0000_0081, 32'h0,         32'h0000_004E, 8'h4E};
    tbl[5]  = '{3'd0, 32'hFFFF_FF00, 32'h0,         32'h0,         8'h00};
    tbl[6]  = '{3'd1, 32'hFFFF_FF3C, 32'h0,         32'h0000_003C, 8'h3C};
    tbl[7]  = '{3'd4, 32'hFFFF_FF80, 32'h0000_0080, 32'h0000_003C, 8'h3C};
    tbl[8]  = '{3'd5, 32'h0001_2345, 32'h0000_2345, 32'h0000_003C, 8'h3C};
    tbl[9]  = '{3'd5, 32'h0000_0000, 32'h0,         32'h0000_003C, 8'h3C};
    tbl[10] = '{3'd4, 32'h0000_0000, 32'h0,         32'h0000_003C, 8'h3C};
    tbl[11] = '{3'd3, 32'h0000_003C, 32'h0,         32'h0,         8'h00};

    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", {24'h0, out_port}, 32'h0);
    for (int a = 0; a < 8; a++)
      rd(3'(a), "reset_read", (a == 6) ? DUTY_RST : 32'h0);
    @(negedge clk);
    reset = 1'b0;

    prev_out = 8'h00;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      wr(tbl[i].waddr, tbl[i].wdata);
      check("out_hold", {24'h0, out_port}, {24'h0, prev_out});
      rd(tbl[i].waddr, "reg_read", tbl[i].exp_rd);
      rd(3'd0, "data_read", tbl[i].exp_data);
      @(posedge clk);
      #1;
      check("out_update", {24'h0, out_port}, {24'h0, tbl[i].exp_out});
      prev_out = tbl[i].exp_out;
    end

    @(negedge clk);
    wr(3'd7, 32'hFFFF_FFFF);
    for (int k = 0; k < CLK_DIV; k++) begin
      @(negedge clk);
      address = 3'd7;
      #1;
      check("status_read", readdata, {30'h0, (m_pre == CLK_DIV - 1), 1'b0});
    end

    // Blink started off a non-tick edge: first toggle after 11 cycles.
    @(negedge clk);
    wr(3'd0, 32'hFF);
    @(negedge clk);
    wr(3'd4, 32'h01);
    align(0);
    wr(3'd5, 32'd3);
    blink_run(HP - 1);

    // BLINK_HALF rewrite on a tick edge: the tick is discarded.
    align(CLK_DIV - 1);
    wr(3'd5, 32'd3);
    blink_run(HP);

    @(negedge clk);
    wr(3'd5, 32'd0);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      check("freeze_out", {24'h0, out_port}, 32'h0000_00FE);
    end

    @(negedge clk);
    wr(3'd4, 32'h0);
    @(negedge clk);
    wr(3'd0, 32'h01);
    pwm_run(8'd64,  PWM ? 64  : 256);
    pwm_run(8'd0,   PWM ? 0   : 256);
    pwm_run(8'd255, 256);
    pwm_run(8'd128, PWM ? 128 : 256);

    @(negedge clk);
    wr(3'd0, 32'hFF);
    @(negedge clk);
    wr(3'd4, 32'h01);
    @(negedge clk);
    wr(3'd5, 32'd3);
    @(negedge clk);
    wr(3'd6, 32'd10);
    found = 0;
    for (int k = 0; k < 300 && found == 0; k++) begin
      @(posedge clk);
      #1;
      if (out_port != 8'h00) found = 1;
    end
    check("pre_reset_active", found, 1);
    #1;
    reset = 1'b1;
    #1;
    check("async_reset_out", {24'h0, out_port}, 32'h0);
    rd(3'd0, "async_reset_data", 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rd(3'd6, "post_reset_duty", DUTY_RST);
    rd(3'd4, "post_reset_mask", 32'h0);
    rd(3'd5, "post_reset_half", 32'h0);
    rd(3'd7, "post_reset_status", 32'h0);
    @(posedge clk);
    #1;
    check("post_reset_out", {24'h0, out_port}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
